// File: rtl/sad_best_mv_tracker.sv
// -----------------------------------------------------------------------------
// sad_best_mv_tracker
//
// Tracks the best motion-vector candidate for a macroblock search. Each accepted
// beat carries the 41 partition SADs produced by the variable-block-size SAD
// tree for one candidate MV. The tracker keeps, per partition, the smallest SAD
// seen so far and the MV that produced it. On the last candidate the result set
// is held for the inter mode-decision stage behind a valid/ready handshake.
//
// Partition index map:
//   0-15 4x4 (row-major [r][c]), 16-23 4x8, 24-31 8x4, 32-35 8x8,
//   36-37 16x8, 38-39 8x16, 40 16x16
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   candidate SAD set valid
//   in_ready   tracker can accept a candidate (low only while holding a result)
//   in_first   first candidate of a new search (restarts from any state)
//   in_last    last candidate of the current search
//   in_sad     packed partition SADs, partition p at [p*SAD_W +: SAD_W]
//   in_mvx/y   signed candidate MV components
//   out_valid  best-result set valid
//   out_ready  downstream accepts the result
//   out_sad    best key per partition (running minimum during a search)
//   out_mvx/y  winning MV per partition
//   out_count  candidates accepted in this search, saturating
//   err_seq    one-cycle pulse: non-first beat accepted while idle (beat dropped)
//
// Configuration macro SAD_MVCOST_EN:
//   defined   - compare key = SAD + ((|mvx|+|mvy|) << LAMBDA_SHIFT), saturated
//               to SAD_W bits; out_sad holds that key.
//   undefined - compare key = raw SAD; no cost logic is built.
// -----------------------------------------------------------------------------
module sad_best_mv_tracker #(
    parameter int SAD_W        = 16,
    parameter int MV_W         = 8,
    parameter int CNT_W        = 10,
    parameter int LAMBDA_SHIFT = 2,
    localparam int NPART       = 41
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic [NPART*SAD_W-1:0]   in_sad,
    input  logic signed [MV_W-1:0]   in_mvx,
    input  logic signed [MV_W-1:0]   in_mvy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NPART*SAD_W-1:0]   out_sad,
    output logic [NPART*MV_W-1:0]    out_mvx,
    output logic [NPART*MV_W-1:0]    out_mvy,
    output logic [CNT_W-1:0]         out_count,
    output logic                     err_seq
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                   w_accept;
    logic                   w_load;
    logic                   w_update;
    logic [SAD_W-1:0]       w_key [NPART];

    logic [NPART*SAD_W-1:0] r_sad;
    logic [NPART*MV_W-1:0]  r_mvx;
    logic [NPART*MV_W-1:0]  r_mvy;
    logic [CNT_W-1:0]       r_count;
    logic                   r_err_seq;

    if (LAMBDA_SHIFT < 0 || LAMBDA_SHIFT > SAD_W) begin : g_bad_lambda
        $error("sad_best_mv_tracker: LAMBDA_SHIFT out of range");
    end

    // -------------------------------------------------------------------------
    // Compare key per partition
    // -------------------------------------------------------------------------
`ifdef SAD_MVCOST_EN
    // Wide enough that SAD + shifted cost never wraps before saturation.
    localparam int KW = SAD_W + MV_W + 1 + LAMBDA_SHIFT;

    logic [MV_W-1:0] w_absx;
    logic [MV_W-1:0] w_absy;
    logic [KW-1:0]   w_cost;

    // Magnitude of the most negative MV fits as an unsigned MV_W value.
    assign w_absx = in_mvx[MV_W-1] ? $unsigned(-in_mvx) : $unsigned(in_mvx);
    assign w_absy = in_mvy[MV_W-1] ? $unsigned(-in_mvy) : $unsigned(in_mvy);
    assign w_cost = (KW'(w_absx) + KW'(w_absy)) << LAMBDA_SHIFT;

    for (genvar p = 0; p < NPART; p++) begin : g_key
        logic [KW-1:0] w_sum;
        assign w_sum    = KW'(in_sad[p*SAD_W +: SAD_W]) + w_cost;
        assign w_key[p] = (|w_sum[KW-1:SAD_W]) ? {SAD_W{1'b1}} : w_sum[SAD_W-1:0];
    end
`else
    for (genvar p = 0; p < NPART; p++) begin : g_key
        assign w_key[p] = in_sad[p*SAD_W +: SAD_W];
    end
`endif

    // -------------------------------------------------------------------------
    // Handshake and FSM
    // -------------------------------------------------------------------------
    assign in_ready  = (r_state != S_HOLD);
    assign out_valid = (r_state == S_HOLD);
    assign w_accept  = in_valid & in_ready;
    assign w_load    = w_accept & in_first;
    // Non-first beats only count inside a search; in IDLE they are dropped.
    assign w_update  = w_accept & ~in_first & (r_state == S_SEARCH);

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: default assigned first so every path drives the signal and no
        // latch is inferred.
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (w_load)    w_state_nxt = in_last ? S_HOLD : S_SEARCH;
            S_SEARCH: if (w_accept)  w_state_nxt = in_last ? S_HOLD : S_SEARCH;
            S_HOLD:   if (out_ready) w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Best-so-far register bank
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the result bank is a flop array, not a RAM, so it is reset
        // to a defined all-ones/zero state with the rest of the block.
        if (!rst) begin
            r_sad     <= '1;
            r_mvx     <= '0;
            r_mvy     <= '0;
            r_count   <= '0;
            r_err_seq <= 1'b0;
        end else begin
            r_err_seq <= w_accept & ~in_first & (r_state == S_IDLE);
            if (w_load) begin
                for (int p = 0; p < NPART; p++) begin
                    r_sad[p*SAD_W +: SAD_W] <= w_key[p];
                    r_mvx[p*MV_W +: MV_W]   <= in_mvx;
                    r_mvy[p*MV_W +: MV_W]   <= in_mvy;
                end
                r_count <= CNT_W'(1);
            end else if (w_update) begin
                // Strict less-than: on a tie the earlier candidate is kept.
                for (int p = 0; p < NPART; p++) begin
                    if (w_key[p] < r_sad[p*SAD_W +: SAD_W]) begin
                        r_sad[p*SAD_W +: SAD_W] <= w_key[p];
                        r_mvx[p*MV_W +: MV_W]   <= in_mvx;
                        r_mvy[p*MV_W +: MV_W]   <= in_mvy;
                    end
                end
                if (r_count != {CNT_W{1'b1}}) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

    assign out_sad   = r_sad;
    assign out_mvx   = r_mvx;
    assign out_mvy   = r_mvy;
    assign out_count = r_count;
    assign err_seq   = r_err_seq;

endmodule
